// File: rtl/read_master_scheduler.sv
// Round-robin scheduler sharing one burst read master among NUM_REQ requesters.
// Captures one descriptor at a time, launches the master and returns a per-requester ack.
//
//   state  | meaning
//   IDLE   | arbitrate among eligible requesters, capture winner's descriptor
//   GO     | control_go pulse to the read master
//   BUSY   | wait for control_done (first cycle ignored while master reloads)
//   RESP   | issue req_ack/req_err, update last_grant and done_count

module read_master_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int ADDRESSWIDTH    = 32,
  parameter int BYTEENABLEWIDTH = 4,
  parameter int GRANTWIDTH      = 2,
  parameter logic [15:0] DONE_COUNT_INIT = 16'h0000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDRESSWIDTH-1:0] req_base,
  input  logic [NUM_REQ*ADDRESSWIDTH-1:0] req_length,
  input  logic [NUM_REQ-1:0]              req_fixed,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic                            req_err,
  output logic                            control_go,
  output logic [ADDRESSWIDTH-1:0]         control_read_base,
  output logic [ADDRESSWIDTH-1:0]         control_read_length,
  output logic                            control_fixed_location,
  input  logic                            control_done,
  output logic                            sched_busy,
  output logic [GRANTWIDTH-1:0]           sched_grant,
  output logic [15:0]                     done_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GO   = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [GRANTWIDTH-1:0]   LAST_INIT = GRANTWIDTH'(NUM_REQ - 1);
  localparam logic [ADDRESSWIDTH-1:0] BEW       = ADDRESSWIDTH'(BYTEENABLEWIDTH);

  logic [1:0]              r_state;
  logic [GRANTWIDTH-1:0]   r_last_grant;
  logic [GRANTWIDTH-1:0]   r_grant;
  logic [ADDRESSWIDTH-1:0] r_base;
  logic [ADDRESSWIDTH-1:0] r_len;
  logic                    r_fixed;
  logic                    r_go;
  logic [NUM_REQ-1:0]      r_ack;
  logic                    r_err;
  logic                    r_busy;
  logic [15:0]             r_done_count;
  logic                    r_reject;
  logic                    r_busy_first;
  logic                    r_mask_acked;

  logic [ADDRESSWIDTH-1:0] w_base_arr [NUM_REQ];
  logic [ADDRESSWIDTH-1:0] w_len_arr  [NUM_REQ];
  logic [NUM_REQ-1:0]      w_mask;
  logic [NUM_REQ-1:0]      w_eligible;
  logic [NUM_REQ-1:0]      w_ack_vec;
  logic                    w_any;
  logic [GRANTWIDTH-1:0]   w_winner;
  logic [GRANTWIDTH-1:0]   w_idx_g;
  int                      w_idx;
  logic [ADDRESSWIDTH-1:0] w_base;
  logic [ADDRESSWIDTH-1:0] w_len;
  logic                    w_fixed;
  logic                    w_bad;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_base_arr[g] = req_base[g*ADDRESSWIDTH +: ADDRESSWIDTH];
    assign w_len_arr[g]  = req_length[g*ADDRESSWIDTH +: ADDRESSWIDTH];
  end

  // The just-acked requester still holds req_valid for one cycle; hide it then.
  always_comb begin
    w_mask = '0;
    if (r_mask_acked) w_mask[r_last_grant] = 1'b1;
    w_eligible = req_valid & ~w_mask;
  end

  // Scan downward so the closest requester after last_grant is written last.
  always_comb begin
    w_any    = 1'b0;
    w_winner = r_last_grant;
    w_idx    = 0;
    w_idx_g  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx   = (int'(r_last_grant) + k) % NUM_REQ;
      w_idx_g = GRANTWIDTH'(w_idx);
      if (w_eligible[w_idx_g]) begin
        w_any    = 1'b1;
        w_winner = w_idx_g;
      end
    end
  end

  always_comb begin
    w_base  = w_base_arr[w_winner];
    w_len   = w_len_arr[w_winner];
    w_fixed = req_fixed[w_winner];
    w_bad   = (w_len == '0) || ((w_base % BEW) != '0) || ((w_len % BEW) != '0);
  end

  always_comb begin
    w_ack_vec          = '0;
    w_ack_vec[r_grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= LAST_INIT;
      r_grant      <= '0;
      r_base       <= '0;
      r_len        <= '0;
      r_fixed      <= 1'b0;
      r_go         <= 1'b0;
      r_ack        <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_done_count <= DONE_COUNT_INIT;
      r_reject     <= 1'b0;
      r_busy_first <= 1'b0;
      r_mask_acked <= 1'b0;
    end else begin
      r_go  <= 1'b0;
      r_ack <= '0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_mask_acked <= 1'b0;
          if (w_any) begin
            r_grant  <= w_winner;
            r_base   <= w_base;
            r_len    <= w_len;
            r_fixed  <= w_fixed;
            r_reject <= w_bad;
            r_busy   <= 1'b1;
            if (w_bad) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_GO;
              r_go    <= 1'b1;
            end
          end
        end
        S_GO: begin
          r_state      <= S_BUSY;
          r_busy_first <= 1'b1;
        end
        S_BUSY: begin
          if (r_busy_first) begin
            r_busy_first <= 1'b0;
          end else if (control_done) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_ack        <= w_ack_vec;
          r_err        <= r_reject;
          r_last_grant <= r_grant;
          r_mask_acked <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
          if (!r_reject) r_done_count <= r_done_count + 16'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ack                = r_ack;
  assign req_err                = r_err;
  assign control_go             = r_go;
  assign control_read_base      = r_base;
  assign control_read_length    = r_len;
  assign control_fixed_location = r_fixed;
  assign sched_busy             = r_busy;
  assign sched_grant            = r_grant;
  assign done_count             = r_done_count;

endmodule

// File: doc/read_master_scheduler.md
READ_MASTER_SCHEDULER -- requirements
Module: read_master_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one burst read master.
REQ-002 SHALL have parameter ADDRESSWIDTH, default 32, address/length width in bytes.
REQ-003 SHALL have parameter BYTEENABLEWIDTH, default 4, bytes per word.
REQ-004 SHALL have parameter GRANTWIDTH, default 2, equal to log2(NUM_REQ).
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester level request.
REQ-008 SHALL have port req_base  input  NUM_REQ*ADDRESSWIDTH  requester i base at [i*ADDRESSWIDTH +: ADDRESSWIDTH].
REQ-009 SHALL have port req_length  input  NUM_REQ*ADDRESSWIDTH  byte length, same packing.
REQ-010 SHALL have port req_fixed  input  NUM_REQ  fixed-location flag per requester.
REQ-011 SHALL have port req_ack  output  NUM_REQ  one-hot, one-cycle completion pulse.
REQ-012 SHALL have port req_err  output  1  qualifies req_ack; 1 = descriptor rejected.
REQ-013 SHALL have port control_go  output  1  one-cycle start pulse to read master.
REQ-014 SHALL have ports control_read_base / control_read_length  output  ADDRESSWIDTH each, and control_fixed_location  output  1; registered descriptor to read master.
REQ-015 SHALL have port control_done  input  1  read master all-reads-returned flag.
REQ-016 SHALL have ports sched_busy  output  1, sched_grant  output  GRANTWIDTH, done_count  output  16 (status).

Function
REQ-017 SHALL implement FSM states IDLE, GO, BUSY, RESP.
REQ-018 IDLE: if any eligible req_valid bit, SHALL select winner round-robin starting at (last_grant+1) mod NUM_REQ, register sched_grant and that requester's base/length/fixed into control_* outputs.
REQ-019 Descriptor invalid when length==0, base mod BYTEENABLEWIDTH!=0, or length mod BYTEENABLEWIDTH!=0; invalid SHALL go IDLE->RESP with req_err=1, no control_go.
REQ-020 Valid descriptor SHALL go IDLE->GO; GO asserts control_go exactly one cycle, then ->BUSY.
REQ-021 BUSY SHALL ignore control_done in its first cycle (master length loads at GO edge), then on control_done==1 go ->RESP.
REQ-022 RESP SHALL assert req_ack[sched_grant]=1 for one cycle, req_err per REQ-019 (0 for completed transfer), update last_grant=sched_grant, ->IDLE.
REQ-023 done_count SHALL increment by 1 (wrapping 0xFFFF->0) on each RESP with req_err=0; rejected descriptors not counted.
REQ-024 Requester holds req_valid and descriptor stable until its ack; deasserts in cycle after ack. Scheduler SHALL mask the just-acked requester in the first IDLE cycle after RESP.
REQ-025 req_valid deasserted while granted SHALL NOT abort; transfer completes and ack still issued.
REQ-026 Descriptor changes after IDLE capture SHALL have no effect on control_* outputs.
REQ-027 sched_busy SHALL be 1 in GO, BUSY, RESP; 0 in IDLE.
REQ-028 Latency valid request in IDLE -> control_go: 1 cycle; control_done observed -> req_ack: 1 cycle.
REQ-029 All outputs SHALL be registered; req_ack one-hot or zero at all times.
REQ-030 Only one transfer SHALL be outstanding; no new capture until IDLE.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), sched_grant=0, control_go=0, control_read_base=0, control_read_length=0, control_fixed_location=0, req_ack=0, req_err=0, sched_busy=0, done_count=0.
REQ-032 Reset mid-transfer SHALL drop state without ack; read master is reset with same reset domain.
REQ-033 Release SHALL be synchronous to clk; first arbitration on first edge after release.

Verification
REQ-034 After reset, req_valid=4'b1111, all valid -> grants in order 0,1,2,3,0; each ack one cycle after control_done.
REQ-035 Req 2 only: base=0x100, length=0x40, fixed=1 -> control_go 1 cycle after request, control_read_base=0x100, length=0x40, fixed=1; done_count 0->1.
REQ-036 Req 1 length=0 -> req_ack=4'b0010 with req_err=1 two cycles after request, no control_go, done_count unchanged; base=0x102 likewise rejected.
REQ-037 control_done held 1 through GO and first BUSY cycle -> no early ack; ack only after done falls and re-rises.
REQ-038 reset_n pulsed low during BUSY -> all outputs at reset values same cycle, no ack emitted; next request granted to requester 0.
REQ-039 done_count preloaded via 65535 completions -> next completion wraps to 0.
